// File: rtl/adapter_axi_stream_2_ppfifo.sv
// AXI-Stream to ping-pong FIFO write-side adapter: claims a free buffer, fills it with
// stream words and releases it on end of packet or when the buffer capacity is reached.
module adapter_axi_stream_2_ppfifo #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_axi_valid,
  output logic                  o_axi_ready,
  input  logic [DATA_WIDTH-1:0] i_axi_data,
  input  logic                  i_axi_last,

  input  logic [1:0]            i_write_ready,
  output logic [1:0]            o_write_activate,
  input  logic [23:0]           i_write_size,
  output logic                  o_write_stb,
  output logic [DATA_WIDTH-1:0] o_write_data,

  output logic                  o_busy
);

  typedef enum logic [1:0] {StIdle, StFill, StRelease} state_e;

  state_e                state_q, state_d;
  logic [23:0]           count_q, count_d;
  logic [1:0]            activate_q, activate_d;
  logic                  stb_q, stb_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  axi_ready;
  logic                  xfer;
  logic [23:0]           count_inc;

  assign count_inc = count_q + 24'd1;
  assign xfer      = i_axi_valid && axi_ready;

  // State register; reset abandons any claimed buffer and drops a pending strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      activate_q <= '0;
      stb_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      activate_q <= activate_d;
      stb_q      <= stb_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    activate_d = activate_q;
    stb_d      = 1'b0;
    data_d     = data_q;

    unique case (state_q)
      StIdle: begin
        if (|i_write_ready) begin
          count_d    = '0;
          // Buffer 0 wins when both are available.
          activate_d = i_write_ready[0] ? 2'b01 : 2'b10;
          state_d    = StFill;
        end
      end

      StFill: begin
        if (xfer) begin
          stb_d   = 1'b1;
          data_d  = i_axi_data;
          count_d = count_inc;
          if (i_axi_last || (count_inc == i_write_size)) begin
            state_d = StRelease;
          end
        end else if (count_q >= i_write_size) begin
          // Covers a zero-sized buffer: release without writing anything.
          state_d = StRelease;
        end
      end

      StRelease: begin
        activate_d = 2'b00;
        state_d    = StIdle;
      end

      default: begin
        activate_d = 2'b00;
        state_d    = StIdle;
      end
    endcase
  end

  always_comb begin
    axi_ready = (state_q == StFill) && (count_q < i_write_size);
  end

  assign o_axi_ready      = axi_ready;
  assign o_write_activate = activate_q;
  assign o_write_stb      = stb_q;
  assign o_write_data     = data_q;
  assign o_busy           = (state_q != StIdle);

endmodule
